// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the tx FIFO and shifts them onto
// the line as start / 8 data LSB-first / optional parity / 1-2 stop bits.
module uart_tx_serializer #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tx_en_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             stop2_i,
    input  logic             fifo_empty_i,
    input  logic [7:0]       fifo_data_i,
    output logic             fifo_rd_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             tx_done_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             par_en_q;
    logic             par_q;
    logic             stop2_q;
    logic             stop_q;

    logic cnt_end;
    logic cnt_pre;
    logic div_one;
    logic last_stop;

    assign cnt_end   = (cnt_q == div_q - DIV_W'(1));
    assign cnt_pre   = (cnt_q == div_q - DIV_W'(2));
    assign div_one   = (div_q == DIV_W'(1));
    assign last_stop = !stop2_q || stop_q;

    // tx_done_o is registered, so it is raised on the edge entering the
    // final cycle of the last stop bit (look-ahead by one count).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            div_q     <= DIV_W'(1);
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            stop_q    <= 1'b0;
            fifo_rd_o <= 1'b0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            tx_done_o <= 1'b0;
        end else begin
            fifo_rd_o <= 1'b0;
            tx_done_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (tx_en_i && !fifo_empty_i) begin
                        state_q   <= FETCH;
                        fifo_rd_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    shift_q  <= fifo_data_i;
                    div_q    <= (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
                    par_en_q <= parity_en_i;
                    par_q    <= (^fifo_data_i) ^ parity_odd_i;
                    stop2_q  <= stop2_i;
                    stop_q   <= 1'b0;
                    cnt_q    <= '0;
                    tx_o     <= 1'b0;
                    state_q  <= START;
                end
                START: begin
                    if (cnt_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_o    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            if (par_en_q) begin
                                tx_o    <= par_q;
                                state_q <= PARITY;
                            end else begin
                                tx_o      <= 1'b1;
                                tx_done_o <= div_one && !stop2_q;
                                state_q   <= STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_o    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt_end) begin
                        cnt_q     <= '0;
                        tx_o      <= 1'b1;
                        tx_done_o <= div_one && !stop2_q;
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_end) begin
                        cnt_q <= '0;
                        if (!last_stop) begin
                            stop_q    <= 1'b1;
                            tx_done_o <= div_one;
                        end else begin
                            busy_o  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q     <= cnt_q + DIV_W'(1);
                        tx_done_o <= last_stop && cnt_pre;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame checks against a small FIFO model
// with hand-computed bit patterns and timing.
module tb_uart_tx_serializer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        tx_en_i;
    logic [15:0] baud_div_i;
    logic        parity_en_i;
    logic        parity_odd_i;
    logic        stop2_i;
    logic        fifo_empty_i;
    logic [7:0]  fifo_data_i = 8'h00;
    logic        fifo_rd_o;
    logic        tx_o;
    logic        busy_o;
    logic        tx_done_o;

    int total = 0;
    int bad   = 0;

    uart_tx_serializer #(.DIV_W(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tx_en_i      (tx_en_i),
        .baud_div_i   (baud_div_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_o    (fifo_rd_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .tx_done_o    (tx_done_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] mem [0:15];
    int wp = 0;
    int rp = 0;

    assign fifo_empty_i = (wp == rp);

    // registered read data, valid the cycle after the pop strobe
    always @(posedge clk_i) begin
        if (fifo_rd_o) begin
            fifo_data_i <= mem[rp % 16];
            rp <= rp + 1;
        end
    end

    int rd_cnt   = 0;
    int done_cnt = 0;
    int rd_err   = 0;

    always @(negedge clk_i) begin
        if (fifo_rd_o === 1'b1) begin
            rd_cnt = rd_cnt + 1;
            if (wp == rp) rd_err = rd_err + 1;
        end
        if (tx_done_o === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wp % 16] = b;
        wp = wp + 1;
    endtask

    bit          cap_ok;
    int          cap_wait;
    logic [15:0] cap_bits;
    bit          cap_stable;
    int          cap_done;
    logic        cap_busy_end;
    logic        cap_busy_after;
    bit          cap_tail;

    // Waits (bounded) for the start bit, then records one sample per bit,
    // bit stability, the tx_done cycle and the line after the frame.
    task automatic capture(input int div, input int nbits, input int poke_at);
        int n;
        logic cur;
        n = 0;
        cur = 1'b1;
        cap_ok = 1'b0;
        cap_bits = '0;
        cap_stable = 1'b1;
        cap_done = -1;
        cap_busy_end = 1'bx;
        cap_busy_after = 1'bx;
        cap_tail = 1'b1;
        while (tx_o !== 1'b0 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        cap_wait = n;
        if (tx_o !== 1'b0) return;
        cap_ok = 1'b1;
        for (int c = 0; c < nbits * div + 3; c++) begin
            if (c == poke_at) begin
                tx_en_i = 1'b0;
                baud_div_i = 16'd8;
            end
            if (c < nbits * div) begin
                if (c % div == 0) begin
                    cur = tx_o;
                    cap_bits[c / div] = tx_o;
                end else if (tx_o !== cur) begin
                    cap_stable = 1'b0;
                end
            end else if (tx_o !== 1'b1) begin
                cap_tail = 1'b0;
            end
            if (c == nbits * div - 1) cap_busy_end = busy_o;
            if (c == nbits * div) cap_busy_after = busy_o;
            if (tx_done_o === 1'b1 && cap_done < 0) cap_done = c;
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        total++;
        if (tx_o !== 1'b1) begin
            bad++; $display("FAIL reset_tx got=%b exp=1", tx_o);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b exp=0", busy_o);
        end
        total++;
        if (fifo_rd_o !== 1'b0) begin
            bad++; $display("FAIL reset_rd got=%b exp=0", fifo_rd_o);
        end
        total++;
        if (tx_done_o !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b exp=0", tx_done_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic;
        int r0, d0;
        logic [15:0] exp;
        baud_div_i = 16'd4;
        parity_en_i = 1'b0;
        stop2_i = 1'b0;
        tx_en_i = 1'b1;
        r0 = rd_cnt;
        d0 = done_cnt;
        exp = {6'b0, 1'b1, 8'hA5, 1'b0};
        push(8'hA5);
        capture(4, 10, -1);
        total++;
        if (!cap_ok) begin
            bad++; $display("FAIL basic_start got=timeout exp=start bit");
        end
        total++;
        if (cap_wait != 3) begin
            bad++; $display("FAIL basic_latency got=%0d exp=3", cap_wait);
        end
        total++;
        if (cap_bits !== exp) begin
            bad++; $display("FAIL basic_bits got=%h exp=%h", cap_bits, exp);
        end
        total++;
        if (!cap_stable) begin
            bad++; $display("FAIL basic_stable got=0 exp=1");
        end
        total++;
        if (cap_done != 39) begin
            bad++; $display("FAIL basic_done_at got=%0d exp=39", cap_done);
        end
        repeat (5) @(negedge clk_i);
        total++;
        if (rd_cnt - r0 != 1) begin
            bad++; $display("FAIL basic_rd got=%0d exp=1", rd_cnt - r0);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++; $display("FAIL basic_done_n got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_parity;
        logic [15:0] exp;
        baud_div_i = 16'd2;
        parity_en_i = 1'b1;
        parity_odd_i = 1'b0;
        exp = {5'b0, 1'b1, 1'b0, 8'h03, 1'b0};
        push(8'h03);
        capture(2, 11, -1);
        total++;
        if (cap_bits !== exp) begin
            bad++; $display("FAIL par_even_bits got=%h exp=%h", cap_bits, exp);
        end
        total++;
        if (cap_done != 21) begin
            bad++; $display("FAIL par_even_done got=%0d exp=21", cap_done);
        end
        parity_odd_i = 1'b1;
        exp = {5'b0, 1'b1, 1'b0, 8'h07, 1'b0};
        push(8'h07);
        capture(2, 11, -1);
        total++;
        if (cap_bits !== exp) begin
            bad++; $display("FAIL par_odd_bits got=%h exp=%h", cap_bits, exp);
        end
        total++;
        if (cap_done != 21 || !cap_stable) begin
            bad++;
            $display("FAIL par_odd_done got=%0d/%0d exp=21/1",
                     cap_done, cap_stable);
        end
        parity_en_i = 1'b0;
        parity_odd_i = 1'b0;
    endtask

    task automatic test_stop2;
        int d0;
        logic [15:0] exp;
        stop2_i = 1'b1;
        baud_div_i = 16'd0;
        d0 = done_cnt;
        exp = {5'b0, 1'b1, 1'b1, 8'h5A, 1'b0};
        push(8'h5A);
        capture(1, 11, -1);
        total++;
        if (cap_bits !== exp) begin
            bad++; $display("FAIL stop2_bits got=%h exp=%h", cap_bits, exp);
        end
        total++;
        if (cap_done != 10) begin
            bad++; $display("FAIL stop2_done_at got=%0d exp=10", cap_done);
        end
        total++;
        if (cap_busy_end !== 1'b1 || cap_busy_after !== 1'b0) begin
            bad++;
            $display("FAIL stop2_busy got=%b%b exp=10",
                     cap_busy_end, cap_busy_after);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++; $display("FAIL stop2_done_n got=%0d exp=1", done_cnt - d0);
        end
        stop2_i = 1'b0;
    endtask

    task automatic test_back_to_back;
        int r0;
        logic [15:0] exp;
        baud_div_i = 16'd2;
        r0 = rd_cnt;
        push(8'h11);
        push(8'h22);
        capture(2, 10, -1);
        exp = {6'b0, 1'b1, 8'h11, 1'b0};
        total++;
        if (cap_bits !== exp) begin
            bad++; $display("FAIL b2b_bits1 got=%h exp=%h", cap_bits, exp);
        end
        total++;
        if (!cap_tail) begin
            bad++; $display("FAIL b2b_gap got=early start exp=3 idle-high cycles");
        end
        capture(2, 10, -1);
        exp = {6'b0, 1'b1, 8'h22, 1'b0};
        total++;
        if (cap_wait != 0 || !cap_ok) begin
            bad++; $display("FAIL b2b_gap2 got=%0d exp=0", cap_wait);
        end
        total++;
        if (cap_bits !== exp) begin
            bad++; $display("FAIL b2b_bits2 got=%h exp=%h", cap_bits, exp);
        end
        repeat (4) @(negedge clk_i);
        total++;
        if (rd_cnt - r0 != 2) begin
            bad++; $display("FAIL b2b_rd got=%0d exp=2", rd_cnt - r0);
        end
    endtask

    task automatic test_disable;
        int r0;
        logic [15:0] exp;
        baud_div_i = 16'd4;
        tx_en_i = 1'b1;
        r0 = rd_cnt;
        push(8'h33);
        push(8'h44);
        capture(4, 10, 14);
        exp = {6'b0, 1'b1, 8'h33, 1'b0};
        total++;
        if (cap_bits !== exp || !cap_stable) begin
            bad++; $display("FAIL dis_bits1 got=%h exp=%h", cap_bits, exp);
        end
        total++;
        if (cap_done != 39) begin
            bad++; $display("FAIL dis_done1 got=%0d exp=39", cap_done);
        end
        repeat (30) @(negedge clk_i);
        total++;
        if (rd_cnt - r0 != 1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL dis_hold got=%0d/%b exp=1/0", rd_cnt - r0, busy_o);
        end
        tx_en_i = 1'b1;
        capture(8, 10, -1);
        exp = {6'b0, 1'b1, 8'h44, 1'b0};
        total++;
        if (cap_wait != 3) begin
            bad++; $display("FAIL dis_latency got=%0d exp=3", cap_wait);
        end
        total++;
        if (cap_bits !== exp || !cap_stable) begin
            bad++; $display("FAIL dis_bits2 got=%h exp=%h", cap_bits, exp);
        end
        total++;
        if (cap_done != 79) begin
            bad++; $display("FAIL dis_done2 got=%0d exp=79", cap_done);
        end
        total++;
        if (rd_cnt - r0 != 2) begin
            bad++; $display("FAIL dis_rd got=%0d exp=2", rd_cnt - r0);
        end
    endtask

    task automatic test_reset_mid;
        int n, r0, d0;
        baud_div_i = 16'd4;
        tx_en_i = 1'b1;
        n = 0;
        push(8'h00);
        while (tx_o !== 1'b0 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        repeat (17) @(negedge clk_i);
        total++;
        if (tx_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre got=%b/%b exp=0/1", tx_o, busy_o);
        end
        #1 rst_ni = 1'b0;
        #1;
        total++;
        if (tx_o !== 1'b1) begin
            bad++; $display("FAIL rstmid_tx got=%b exp=1", tx_o);
        end
        total++;
        if (busy_o !== 1'b0 || fifo_rd_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_busy_rd got=%b/%b exp=0/0",
                     busy_o, fifo_rd_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        r0 = rd_cnt;
        d0 = done_cnt;
        repeat (10) @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_idle got=%b/%b exp=0/1", busy_o, tx_o);
        end
        total++;
        if (rd_cnt - r0 != 0 || done_cnt - d0 != 0) begin
            bad++;
            $display("FAIL rstmid_quiet got=%0d/%0d exp=0/0",
                     rd_cnt - r0, done_cnt - d0);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        tx_en_i = 1'b0;
        baud_div_i = 16'd4;
        parity_en_i = 1'b0;
        parity_odd_i = 1'b0;
        stop2_i = 1'b0;
        test_reset;
        test_basic;
        test_parity;
        test_stop2;
        test_back_to_back;
        test_disable;
        test_reset_mid;
        total++;
        if (rd_err != 0) begin
            bad++; $display("FAIL rd_when_empty got=%0d exp=0", rd_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Downstream stage of the UART transmit FIFO. Pops one byte at a time from the FIFO and serialises it onto the UART TX line. Each frame is: start bit, 8 data bits LSB-first, optional parity bit, then 1 or 2 stop bits. The bit period is a programmable number of clock cycles, and `done`/`busy` status is reported to the register block.

Parameters:
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- tx_en_i  input  1  enable; a new frame starts only while high.
- baud_div_i  input  DIV_W  clock cycles per bit; 0 is treated as 1.
- parity_en_i  input  1  1 = insert a parity bit after the data bits.
- parity_odd_i  input  1  1 = odd parity, 0 = even parity.
- stop2_i  input  1  1 = two stop bits, 0 = one stop bit.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_data_i  input  8  FIFO read data; registered, valid the cycle after fifo_rd_o.
- fifo_rd_o  output  1  one-cycle FIFO pop strobe.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high in every state except IDLE.
- tx_done_o  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - State = IDLE, tx_o = 1, fifo_rd_o = 0, busy_o = 0, tx_done_o = 0.
  - Baud counter, bit counter and shift register cleared.
  - A frame that is in progress is abandoned; the line returns high at once.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - If tx_en_i = 1 and fifo_empty_i = 0 at a rising edge, go to FETCH.
  - Otherwise stay in IDLE with tx_o = 1.
- FETCH (exactly 1 cycle):
  - fifo_rd_o = 1. It is a registered Moore output and is high only in this state.
  - Next state is LOAD.
- LOAD (exactly 1 cycle):
  - Capture fifo_data_i into the shift register.
  - Latch the configuration for the whole frame: eff_div = max(baud_div_i, 1), parity_en_i, parity_odd_i, stop2_i.
  - Parity bit = XOR of the 8 data bits, inverted when parity_odd_i = 1.
  - Next state is START.
  - Config inputs that change mid-frame therefore have no effect until the next frame.
- Bit timing:
  - tx_o is registered and updates on the edge that enters each bit.
  - Every bit, including the start bit, holds for exactly eff_div cycles.
  - The baud counter counts 0 .. eff_div-1. The bit advances when the counter reaches eff_div-1.
- START: tx_o = 0 for one bit period, then go to DATA.
- DATA:
  - 8 bits, LSB first. The shift register shifts right after each bit.
  - A 3-bit counter tracks the bits; after bit 7, go to PARITY if parity is enabled, else to STOP.
- PARITY: tx_o = parity bit for one bit period, then go to STOP.
- STOP:
  - tx_o = 1 for 1 or 2 bit periods.
  - On the final cycle of the last stop bit, assert tx_done_o (registered, high for exactly 1 cycle) and go to IDLE.
- Back-to-back frames:
  - There is at least one IDLE cycle between frames.
  - If the FIFO is still non-empty and tx_en_i = 1, FETCH follows that single IDLE cycle.
  - Timeline: fifo_rd_o rises 1 cycle after leaving STOP; the next start bit follows 3 cycles after leaving STOP.
- Latency: FIFO non-empty at edge T0 → fifo_rd_o high in cycle T1 → data captured in T2 → tx_o falls at edge T3.
- Disable: deasserting tx_en_i mid-frame does not abort the frame; the current frame completes and no new fetch occurs.
- FIFO interaction:
  - fifo_rd_o is never issued when fifo_empty_i = 1.
  - The FIFO's empty and data state is sampled only in IDLE and LOAD.
- Frame length:
  - With eff_div = d, total frame length = d × (10 + parity_en + stop2) cycles, from the tx_o falling edge to tx_done_o inclusive.
  - Counter widths must not overflow for baud_div_i = 2^DIV_W − 1.

Test Plan:
- Basic frame: reset, baud_div_i = 4, 8N1, FIFO holds 0xA5, tx_en_i = 1.
  - Exactly one fifo_rd_o pulse.
  - tx_o = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles.
  - tx_done_o pulses once, 40 cycles after tx_o falls.
- Even parity: 0x03 with parity_en_i = 1, parity_odd_i = 0, then 0x07 with parity_odd_i = 1.
  - Parity bit = 0 for 0x03; parity bit = 0 for 0x07.
  - 11 bit periods per frame.
- Two stop bits with minimum divisor: stop2_i = 1, baud_div_i = 0 (treated as 1).
  - Frame is 11 cycles; stop high for 2 cycles; busy_o drops the cycle after tx_done_o.
- Back-to-back: FIFO holds 0x11 and 0x22, baud_div_i = 2.
  - Two fifo_rd_o pulses.
  - Second start bit begins exactly 3 cycles after the first frame's STOP ends.
  - Data bits are correct for both bytes.
- Mid-frame disable and config change: clear tx_en_i and change baud_div_i to 8 during the DATA bits of a baud_div_i = 4 frame, with 2 bytes queued.
  - Current frame completes at 4 cycles/bit.
  - No further fifo_rd_o is issued.
  - Re-enabling sends the second byte at 8 cycles/bit.
- Reset mid-frame: assert rst_ni low during bit 3 of a frame.
  - tx_o = 1, busy_o = 0, fifo_rd_o = 0 immediately, without waiting for a clock edge.
  - After release with the FIFO empty, the block stays in IDLE.
